// File: rtl/riscv_apu_resp_pkg.sv
// Shared types for the APU responder: op encoding, divider states, result-flag bit positions.
package riscv_apu_resp_pkg;

  typedef enum logic [1:0] {
    APU_ADD  = 2'd0,
    APU_SUB  = 2'd1,
    APU_MUL  = 2'd2,
    APU_DIVU = 2'd3
  } apu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int RFLAG_DZ   = 0;
  localparam int RFLAG_ZERO = 1;

endpackage

// File: rtl/riscv_apu_resp_div.sv
// Iterative restoring unsigned divider: start in IDLE, WIDTH RUN steps, done pulses for one cycle in DONE.
// A zero divisor naturally yields an all-ones quotient; dz_o flags it. No backpressure: done is a 1-cycle strobe.
module riscv_apu_resp_div
  import riscv_apu_resp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic             dz_o
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q, div_q;
  logic             dz_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  // Shift in the next dividend bit; the remainder before shifting is always < divisor.
  assign rem_sh  = {rem_q, quot_q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, div_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - div_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start_i) state_d = DIV_RUN;
      DIV_RUN:  if (cnt_q == '0) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && start_i) begin
        quot_q <= dividend_i;
        rem_q  <= '0;
        div_q  <= divisor_i;
        dz_q   <= (divisor_i == '0);
        cnt_q  <= CNTW'(WIDTH - 1);
      end else if (state_q == DIV_RUN) begin
        quot_q <= {quot_q[WIDTH-2:0], ge};
        rem_q  <= ge ? rem_sub : rem_sh[WIDTH-1:0];
        cnt_q  <= cnt_q - CNTW'(1);
      end
    end
  end

  assign busy_o = (state_q != DIV_IDLE);
  assign done_o = (state_q == DIV_DONE);
  assign quot_o = quot_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/riscv_apu_resp.sv
// APU responder: ADD/SUB (push N+1), MUL (push N+2), DIVU (push N+WIDTH+1) into an in-order result FIFO.
// Grant is withheld when credits run out, the divider is busy, or an ADD/SUB would collide with a MUL completion.
module riscv_apu_resp
  import riscv_apu_resp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RES_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  apu_slave_req_i,
  output logic                  apu_slave_gnt_o,
  input  logic [1:0]            apu_slave_op_i,
  input  logic [1:0][WIDTH-1:0] apu_slave_operands_i,
  output logic                  apu_slave_valid_o,
  input  logic                  apu_slave_ready_i,
  output logic [WIDTH-1:0]      apu_slave_result_o,
  output logic [1:0]            apu_slave_rflags_o,
  output logic                  busy_o
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 5);
  localparam int FW = WIDTH + 2;

  apu_op_e          op;
  logic             is_addsub, credit_ok, accept, div_start;
  logic [CW-1:0]    outstanding;

  logic             add_valid_q;
  logic [WIDTH-1:0] add_res_q;
  logic             mul_s1_valid_q, mul_s2_valid_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q, mul_res_q;

  logic             div_busy, div_done, div_dz;
  logic [WIDTH-1:0] div_quot;

  logic             push, pop, fifo_valid;
  logic [WIDTH-1:0] push_res;
  logic [1:0]       push_flags;
  logic [FW-1:0]    fifo_mem [RES_DEPTH];
  logic [FW-1:0]    head;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    fifo_cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign op        = apu_op_e'(apu_slave_op_i);
  assign is_addsub = (op == APU_ADD) || (op == APU_SUB);

  // Every accepted op holds a credit from accept until its FIFO entry is popped.
  assign outstanding = fifo_cnt_q + CW'(add_valid_q) + CW'(mul_s1_valid_q)
                     + CW'(mul_s2_valid_q) + CW'(div_busy);
  assign credit_ok   = outstanding < CW'(RES_DEPTH);

  assign apu_slave_gnt_o = apu_slave_req_i & credit_ok & ~div_busy
                         & ~(is_addsub & mul_s1_valid_q);
  assign accept    = apu_slave_gnt_o;
  assign div_start = accept & (op == APU_DIVU);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_valid_q    <= 1'b0;
      add_res_q      <= '0;
      mul_s1_valid_q <= 1'b0;
      mul_s2_valid_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_res_q      <= '0;
    end else begin
      add_valid_q    <= accept & is_addsub;
      mul_s1_valid_q <= accept & (op == APU_MUL);
      mul_s2_valid_q <= mul_s1_valid_q;
      if (accept && is_addsub) begin
        add_res_q <= (op == APU_SUB) ? apu_slave_operands_i[0] - apu_slave_operands_i[1]
                                     : apu_slave_operands_i[0] + apu_slave_operands_i[1];
      end
      if (accept && op == APU_MUL) begin
        mul_a_q <= apu_slave_operands_i[0];
        mul_b_q <= apu_slave_operands_i[1];
      end
      if (mul_s1_valid_q) mul_res_q <= mul_a_q * mul_b_q;
    end
  end

  riscv_apu_resp_div #(.WIDTH(WIDTH)) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (div_start),
    .dividend_i (apu_slave_operands_i[0]),
    .divisor_i  (apu_slave_operands_i[1]),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .dz_o       (div_dz)
  );

  // Grant rules leave at most one completion source active per cycle.
  always_comb begin
    push       = 1'b0;
    push_res   = '0;
    push_flags = '0;
    if (add_valid_q) begin
      push     = 1'b1;
      push_res = add_res_q;
    end else if (mul_s2_valid_q) begin
      push     = 1'b1;
      push_res = mul_res_q;
    end else if (div_done) begin
      push                 = 1'b1;
      push_res             = div_quot;
      push_flags[RFLAG_DZ] = div_dz;
    end
    push_flags[RFLAG_ZERO] = (push_res == '0);
  end

  assign fifo_valid = (fifo_cnt_q != '0);
  assign pop        = fifo_valid & apu_slave_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {push_flags, push_res};
  end

  assign head               = fifo_mem[rd_ptr_q];
  assign apu_slave_valid_o  = fifo_valid;
  assign apu_slave_result_o = fifo_valid ? head[WIDTH-1:0] : '0;
  assign apu_slave_rflags_o = fifo_valid ? head[FW-1:WIDTH] : '0;
  assign busy_o             = (outstanding != '0);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (fifo_cnt_q < CW'(RES_DEPTH)));

endmodule

// File: tb/tb_riscv_apu_resp.sv
// Directed bench for riscv_apu_resp: vector table for arithmetic/latency, hand sequences for ordering, backpressure, reset.
module tb_riscv_apu_resp;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req;
  logic          gnt;
  logic [1:0]    op;
  logic [1:0][W-1:0] operands;
  logic          valid;
  logic          ready;
  logic [W-1:0]  result;
  logic [1:0]    rflags;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  riscv_apu_resp #(.WIDTH(W), .RES_DEPTH(2)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .apu_slave_req_i      (req),
    .apu_slave_gnt_o      (gnt),
    .apu_slave_op_i       (op),
    .apu_slave_operands_i (operands),
    .apu_slave_valid_o    (valid),
    .apu_slave_ready_i    (ready),
    .apu_slave_result_o   (result),
    .apu_slave_rflags_o   (rflags),
    .busy_o               (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [1:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    req = 1'b1;
    op = o;
    operands[0] = a;
    operands[1] = b;
  endtask

  // Present a request, wait (bounded) for grant, return once the accept edge has passed.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int waits);
    drive(o, a, b);
    #1;
    waits = 0;
    while (!gnt && waits < 200) begin
      tick();
      #1;
      waits++;
    end
    tick();
    req = 1'b0;
  endtask

  initial begin
    int waits, lat, bad, seen;
    logic [31:0] held;

    vecs[0]  = '{2'd0, 32'd5,          32'd7,          32'd12,         2'b00, 2};
    vecs[1]  = '{2'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  2'b00, 2};
    vecs[2]  = '{2'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          2'b10, 2};
    vecs[3]  = '{2'd1, 32'd9,          32'd9,          32'd0,          2'b10, 2};
    vecs[4]  = '{2'd2, 32'd3,          32'd4,          32'd12,         2'b00, 3};
    vecs[5]  = '{2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          2'b00, 3};
    vecs[6]  = '{2'd2, 32'h0001_0000,  32'h0001_0000,  32'd0,          2'b10, 3};
    vecs[7]  = '{2'd3, 32'd100,        32'd7,          32'd14,         2'b00, 34};
    vecs[8]  = '{2'd3, 32'd9,          32'd0,          32'hFFFF_FFFF,  2'b01, 34};
    vecs[9]  = '{2'd3, 32'd0,          32'd5,          32'd0,          2'b10, 34};
    vecs[10] = '{2'd3, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  2'b00, 34};
    vecs[11] = '{2'd3, 32'd7,          32'd100,        32'd0,          2'b10, 34};

    rst_ni = 1'b0;
    req = 1'b0;
    op = 2'd0;
    operands = '0;
    ready = 1'b1;
    tick();
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rflags", {30'd0, rflags}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Vector table: grant, latency, result, flags, idle after pop.
    for (int i = 0; i < 12; i++) begin
      ready = 1'b1;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, waits);
      check($sformatf("vec%0d_gnt_wait", i), waits, 0);
      lat = 1;
      #1;
      while (!valid && lat < 200) begin
        tick();
        #1;
        lat++;
      end
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_res", i), result, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {30'd0, rflags}, {30'd0, vecs[i].flg});
      tick();
      check($sformatf("vec%0d_idle", i), {31'd0, busy}, 32'd0);
      tick();
    end

    // MUL then ADD: the ADD is held off while MUL stage 1 is occupied.
    drive(2'd2, 32'd3, 32'd4);
    #1;
    check("mulfirst_gnt", {31'd0, gnt}, 32'd1);
    tick();
    drive(2'd0, 32'd1, 32'd1);
    #1;
    check("addblk_gnt_c1", {31'd0, gnt}, 32'd0);
    tick();
    #1;
    check("addblk_gnt_c2", {31'd0, gnt}, 32'd1);
    tick();
    req = 1'b0;
    #1;
    check("order_v0", {31'd0, valid}, 32'd1);
    check("order_r0", result, 32'd12);
    tick();
    check("order_v1", {31'd0, valid}, 32'd1);
    check("order_r1", result, 32'd2);
    tick();
    check("order_empty", {31'd0, valid}, 32'd0);
    tick();

    // DIVU: no grant for any request while the divider is occupied.
    issue(2'd3, 32'd100, 32'd7, waits);
    drive(2'd0, 32'd1, 32'd1);
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      #1;
      if (gnt || valid) bad++;
      tick();
    end
    req = 1'b0;
    check("div_run_no_gnt", bad, 0);
    #1;
    check("div_c34_valid", {31'd0, valid}, 32'd1);
    check("div_c34_res", result, 32'd14);
    tick();
    tick();

    // Backpressure: two credits, third request waits until the cycle after the first pop.
    ready = 1'b0;
    drive(2'd0, 32'd1, 32'd2);
    #1;
    check("bp_gnt0", {31'd0, gnt}, 32'd1);
    tick();
    drive(2'd0, 32'd3, 32'd4);
    #1;
    check("bp_gnt1", {31'd0, gnt}, 32'd1);
    tick();
    drive(2'd0, 32'd5, 32'd6);
    bad = 0;
    held = result;
    for (int c = 2; c <= 5; c++) begin
      #1;
      if (gnt || !valid || result !== 32'd3) bad++;
      tick();
    end
    check("bp_hold", bad, 0);
    ready = 1'b1;
    #1;
    check("bp_pop_cycle_gnt", {31'd0, gnt}, 32'd0);
    check("bp_head0", result, 32'd3);
    tick();
    #1;
    check("bp_after_pop_gnt", {31'd0, gnt}, 32'd1);
    check("bp_head1", result, 32'd7);
    tick();
    req = 1'b0;
    #1;
    check("bp_gap", {31'd0, valid}, 32'd0);
    tick();
    check("bp_head2", result, 32'd11);
    check("bp_head2_v", {31'd0, valid}, 32'd1);
    tick();
    check("bp_idle", {31'd0, busy}, 32'd0);
    tick();

    // Reset during DIVU RUN with one FIFO entry held.
    ready = 1'b0;
    issue(2'd0, 32'd1, 32'd1, waits);
    issue(2'd3, 32'd50, 32'd5, waits);
    check("rstmid_div_gnt", waits, 0);
    for (int c = 0; c < 5; c++) tick();
    check("rstmid_pre_valid", {31'd0, valid}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, valid}, 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_rflags", {30'd0, rflags}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_gnt", {31'd0, gnt}, 32'd0);
    tick();
    tick();
    rst_ni = 1'b1;
    ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (valid || busy) seen++;
    end
    check("rstmid_nothing_after", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
